// File: rtl/keypad_scan_if.sv
// keypad_scan_if: key-event handshake between keypad_scan and the peripheral
//   key_code  [3:0] code of the most recent accepted press (4*row + col)
//   key_valid       press event pending, held until acked
//   key_ack         one-cycle consume pulse from the peripheral
//   key_down        a debounced key is currently held
//   overrun         a press was accepted while an unacked one was pending
//   master: keypad_scan side, slave: peripheral side
interface keypad_scan_if;
    logic [3:0] key_code;
    logic       key_valid;
    logic       key_ack;
    logic       key_down;
    logic       overrun;
    modport master(output key_code, key_valid, key_down, overrun, input key_ack);
    modport slave(input key_code, key_valid, key_down, overrun, output key_ack);
endinterface

// File: rtl/keypad_scan.sv
// keypad_scan: 4x4 matrix keypad scanner with per-frame debounce and key event handshake
//   clk            system clock, posedge
//   rst            asynchronous active-low reset
//   io_keypad_row  row sense lines, active-low, asynchronous to clk
//   io_keypad_col  column drive, active-low, one-hot-low, registered
//   kp             key event interface (master side)
module keypad_scan #(
    parameter int SCAN_DIV = 50000,
    parameter int DEBOUNCE = 4
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [3:0]    io_keypad_row,
    output logic [3:0]    io_keypad_col,
    keypad_scan_if.master kp
);
    localparam int DW = $clog2(SCAN_DIV);
    localparam logic [3:0] DEB = 4'(DEBOUNCE);

    typedef enum logic [1:0] {IDLE, PRESS_DEB, HELD, REL_DEB} state_t;

    logic [DW-1:0] div_cnt;
    logic [1:0]    col_idx;
    logic [3:0]    row_s1, row_s2;
    logic [15:0]   keys_q, keys_f;
    logic          tick, frame_end;
    logic [4:0]    n_closed;
    logic [3:0]    k_idx;
    logic          none, single;
    state_t        state, state_nx;
    logic [3:0]    cnt, cnt_nx, cand, cand_nx;
    logic          emit;

    assign tick      = div_cnt == DW'(SCAN_DIV - 1);
    assign frame_end = tick && col_idx == 2'd3;

    // Column stepping, row synchronizer and per-column capture of closed keys.
    // keys_q holds the last captured state of every key; each column is
    // rewritten once per frame, so no explicit clear is needed.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            div_cnt       <= '0;
            col_idx       <= '0;
            io_keypad_col <= 4'b1110;
            row_s1        <= '0;
            row_s2        <= '0;
            keys_q        <= '0;
        end else begin
            row_s1  <= io_keypad_row;
            row_s2  <= row_s1;
            div_cnt <= tick ? '0 : div_cnt + 1'b1;
            if (tick) begin
                col_idx       <= col_idx + 2'd1;
                io_keypad_col <= ~(4'b1 << (col_idx + 2'd1));
                keys_q        <= keys_f;
            end
        end
    end

    // Key map including the column being captured right now, so the
    // frame-end decision sees all four columns of the finished frame.
    always_comb begin
        keys_f = keys_q;
        for (int r = 0; r < 4; r++)
            keys_f[{r[1:0], col_idx}] = ~row_s2[r];
    end

    always_comb begin
        n_closed = '0;
        k_idx    = '0;
        for (int i = 0; i < 16; i++)
            if (keys_f[i]) begin
                n_closed = n_closed + 5'd1;
                k_idx    = 4'(i);
            end
    end

    assign none   = n_closed == 5'd0;
    assign single = n_closed == 5'd1;

    // FSM state register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
            cnt   <= '0;
            cand  <= '0;
        end else begin
            state <= state_nx;
            cnt   <= cnt_nx;
            cand  <= cand_nx;
        end
    end

    // FSM next state, evaluated only at frame end
    always_comb begin
        state_nx = state;
        cnt_nx   = cnt;
        cand_nx  = cand;
        emit     = 1'b0;
        if (frame_end) begin
            unique case (state)
                IDLE: if (single) begin
                    cand_nx = k_idx;
                    if (DEBOUNCE == 1) begin
                        state_nx = HELD;
                        cnt_nx   = '0;
                        emit     = 1'b1;
                    end else begin
                        state_nx = PRESS_DEB;
                        cnt_nx   = 4'd1;
                    end
                end
                PRESS_DEB: if (single && k_idx == cand) begin
                    cnt_nx = cnt + 4'd1;
                    if (cnt_nx == DEB) begin
                        state_nx = HELD;
                        cnt_nx   = '0;
                        emit     = 1'b1;
                    end
                end else begin
                    // a different key is not adopted here; it restarts from IDLE
                    state_nx = IDLE;
                    cnt_nx   = '0;
                end
                HELD: if (none) begin
                    state_nx = DEBOUNCE == 1 ? IDLE : REL_DEB;
                    cnt_nx   = DEBOUNCE == 1 ? 4'd0 : 4'd1;
                end
                REL_DEB: if (none) begin
                    cnt_nx = cnt + 4'd1;
                    if (cnt_nx == DEB) begin
                        state_nx = IDLE;
                        cnt_nx   = '0;
                    end
                end else begin
                    state_nx = HELD;
                    cnt_nx   = '0;
                end
            endcase
        end
    end

    // FSM outputs
    always_comb begin
        kp.key_down = state == HELD || state == REL_DEB;
    end

    // Event register: a new event always wins over a same-cycle ack
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            kp.key_code  <= '0;
            kp.key_valid <= 1'b0;
            kp.overrun   <= 1'b0;
        end else if (emit) begin
            kp.key_code  <= cand_nx;
            kp.key_valid <= 1'b1;
            kp.overrun   <= kp.key_valid && !kp.key_ack;
        end else if (kp.key_ack && kp.key_valid) begin
            kp.key_valid <= 1'b0;
            kp.overrun   <= 1'b0;
        end
    end
endmodule
